// File: rtl/color_xform_pkg.sv
// Shared term indices, channel selects and the identity coefficient rule for the
// cubic colour transform; coefficient 1.0 is 2^frac.
package color_xform_pkg;

  localparam int T_R3    = 0;
  localparam int T_G3    = 1;
  localparam int T_B3    = 2;
  localparam int T_R2G   = 3;
  localparam int T_RG2   = 4;
  localparam int T_G2B   = 5;
  localparam int T_GB2   = 6;
  localparam int T_B2R   = 7;
  localparam int T_BR2   = 8;
  localparam int T_R2    = 9;
  localparam int T_G2    = 10;
  localparam int T_B2    = 11;
  localparam int T_RG    = 12;
  localparam int T_GB    = 13;
  localparam int T_BR    = 14;
  localparam int T_R     = 15;
  localparam int T_G     = 16;
  localparam int T_B     = 17;
  localparam int T_CONST = 18;
  localparam int NTERMS  = 19;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int NCH  = 3;

  // Channel ch passes its own linear term at unity gain, everything else is zero.
  function automatic int ident_coef(input int ch, input int term, input int frac);
    return (term == T_R + ch) ? (1 << frac) : 0;
  endfunction

endpackage

// File: rtl/color_xform_mac.sv
// One output channel: registered coefficient x monomial products, then a combinational
// sum, round-half-up and clamp. Advances only with en; holds state while stalled.
module color_xform_mac
  import color_xform_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CW   = 18,
  parameter int FRAC = 10
) (
  input  logic                 clk_25,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [CW-1:0] coef [NTERMS],
  input  logic [3*DW-1:0]      mono [NTERMS],
  output logic [DW-1:0]        res
);

  localparam int PW   = CW + 3*DW + 1;
  localparam int ACCW = 3*DW + CW + 6;
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1 << (FRAC-1));
  localparam logic signed [ACCW-1:0] MAXV = ACCW'((1 << DW) - 1);

  logic signed [PW-1:0]   prod [NTERMS];
  logic signed [ACCW-1:0] acc, rnd, shr;

  // Monomials are unsigned: a zero sign bit keeps the signed multiply exact.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < NTERMS; t++) prod[t] <= '0;
    end else if (en) begin
      for (int t = 0; t < NTERMS; t++)
        prod[t] <= PW'(coef[t]) * PW'($signed({1'b0, mono[t]}));
    end
  end

  always_comb begin
    acc = '0;
    for (int t = 0; t < NTERMS; t++) acc = acc + ACCW'(prod[t]);
    rnd = acc + HALF;
    shr = rnd >>> FRAC;
    res = '0;
    if (shr[ACCW-1])      res = '0;
    else if (shr > MAXV)  res = '1;
    else                  res = shr[DW-1:0];
  end

endmodule

// File: rtl/color_xform_poly.sv
// Pipelined cubic RGB corrector with double-buffered coefficients; pixel out 3 edges after
// acceptance. wrfull with a pending output freezes every stage; ready drops while stalled or committing.
module color_xform_poly
  import color_xform_pkg::*;
#(
  parameter int DW   = 8,
  parameter int XYW  = 10,
  parameter int CW   = 18,
  parameter int FRAC = 10
) (
  input  logic                 clk_25,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic [XYW-1:0]       x_i,
  input  logic [XYW-1:0]       y_i,
  input  logic [DW-1:0]        red_i,
  input  logic [DW-1:0]        green_i,
  input  logic [DW-1:0]        blue_i,
  input  logic                 bypass,
  input  logic                 wrfull,
  output logic                 wrreq,
  output logic                 wrclk_25,
  output logic [XYW-1:0]       x_o,
  output logic [XYW-1:0]       y_o,
  output logic [DW-1:0]        red_o,
  output logic [DW-1:0]        green_o,
  output logic [DW-1:0]        blue_o,
  input  logic                 cfg_we,
  input  logic [6:0]           cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  input  logic                 cfg_commit,
  output logic                 commit_pending
);

  localparam int MW = 3*DW;

  logic                 en, accept, out_vld, drained;
  logic                 v0, v1, v2, byp0, byp1, byp2;
  logic [XYW-1:0]       x0, y0, x1, y1, x2, y2;
  logic [DW-1:0]        r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic [MW-1:0]        rw, gw, bw;
  logic [MW-1:0]        mono_c [NTERMS];
  logic [MW-1:0]        mono1  [NTERMS];
  logic signed [CW-1:0] act_bank [NCH][NTERMS];
  logic signed [CW-1:0] shd_bank [NCH][NTERMS];
  logic [DW-1:0]        mac_res [NCH];
  logic [1:0]           cfg_ch;
  logic [4:0]           cfg_idx;

  assign en       = !(out_vld && wrfull);
  assign ready    = en && !commit_pending;
  assign accept   = valid && ready;
  assign wrreq    = out_vld && !wrfull;
  assign wrclk_25 = clk_25;
  assign drained  = !(v0 || v1 || v2 || out_vld);
  assign cfg_ch   = cfg_addr[6:5];
  assign cfg_idx  = cfg_addr[4:0];

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      v0 <= 1'b0; byp0 <= 1'b0; x0 <= '0; y0 <= '0; r0 <= '0; g0 <= '0; b0 <= '0;
    end else if (en) begin
      v0 <= accept;
      if (accept) begin
        byp0 <= bypass; x0 <= x_i; y0 <= y_i;
        r0 <= red_i; g0 <= green_i; b0 <= blue_i;
      end
    end
  end

  always_comb begin
    rw = MW'(r0);
    gw = MW'(g0);
    bw = MW'(b0);
    mono_c[T_R3]    = rw * rw * rw;
    mono_c[T_G3]    = gw * gw * gw;
    mono_c[T_B3]    = bw * bw * bw;
    mono_c[T_R2G]   = rw * rw * gw;
    mono_c[T_RG2]   = rw * gw * gw;
    mono_c[T_G2B]   = gw * gw * bw;
    mono_c[T_GB2]   = gw * bw * bw;
    mono_c[T_B2R]   = bw * bw * rw;
    mono_c[T_BR2]   = bw * rw * rw;
    mono_c[T_R2]    = rw * rw;
    mono_c[T_G2]    = gw * gw;
    mono_c[T_B2]    = bw * bw;
    mono_c[T_RG]    = rw * gw;
    mono_c[T_GB]    = gw * bw;
    mono_c[T_BR]    = bw * rw;
    mono_c[T_R]     = rw;
    mono_c[T_G]     = gw;
    mono_c[T_B]     = bw;
    mono_c[T_CONST] = MW'(1);
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; byp1 <= 1'b0; x1 <= '0; y1 <= '0; r1 <= '0; g1 <= '0; b1 <= '0;
      v2 <= 1'b0; byp2 <= 1'b0; x2 <= '0; y2 <= '0; r2 <= '0; g2 <= '0; b2 <= '0;
      for (int t = 0; t < NTERMS; t++) mono1[t] <= '0;
    end else if (en) begin
      v1 <= v0; byp1 <= byp0; x1 <= x0; y1 <= y0; r1 <= r0; g1 <= g0; b1 <= b0;
      v2 <= v1; byp2 <= byp1; x2 <= x1; y2 <= y1; r2 <= r1; g2 <= g1; b2 <= b1;
      for (int t = 0; t < NTERMS; t++) mono1[t] <= mono_c[t];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_mac
    color_xform_mac #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_mac (
      .clk_25 (clk_25),
      .reset  (reset),
      .en     (en),
      .coef   (act_bank[c]),
      .mono   (mono1),
      .res    (mac_res[c])
    );
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0; x_o <= '0; y_o <= '0;
      red_o <= '0; green_o <= '0; blue_o <= '0;
    end else if (en) begin
      out_vld <= v2;
      x_o     <= x2;
      y_o     <= y2;
      red_o   <= byp2 ? r2 : mac_res[CH_R];
      green_o <= byp2 ? g2 : mac_res[CH_G];
      blue_o  <= byp2 ? b2 : mac_res[CH_B];
    end
  end

  // The copy reads shadow before this edge's write lands, so a coincident write waits for the next commit.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      commit_pending <= 1'b0;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTERMS; t++) begin
          act_bank[c][t] <= CW'(ident_coef(c, t, FRAC));
          shd_bank[c][t] <= CW'(ident_coef(c, t, FRAC));
        end
    end else begin
      if (cfg_we && cfg_ch <= 2'(CH_B) && cfg_idx < 5'(NTERMS))
        shd_bank[cfg_ch][cfg_idx] <= cfg_data;
      if (commit_pending && drained) begin
        commit_pending <= 1'b0;
        for (int c = 0; c < NCH; c++)
          for (int t = 0; t < NTERMS; t++) act_bank[c][t] <= shd_bank[c][t];
      end else if (cfg_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_color_xform_poly.sv
// Bench for color_xform_poly: random and directed pixels checked against a polynomial
// reference model with its own copy of the coefficient banks.
module tb_color_xform_poly;

  typedef struct packed {
    logic [9:0] x, y;
    logic [7:0] r, g, b;
  } pix_t;

  typedef struct packed {
    logic       byp;
    logic [9:0] x, y;
    logic [7:0] r, g, b;
  } src_t;

  logic        clk_25, reset, valid, ready, bypass, wrfull, wrreq, wrclk_25;
  logic        cfg_we, cfg_commit, commit_pending;
  logic [9:0]  x_i, y_i, x_o, y_o;
  logic [7:0]  red_i, green_i, blue_i, red_o, green_o, blue_o;
  logic [6:0]  cfg_addr;
  logic [17:0] cfg_data;

  int   tests = 0, fails = 0;
  int   act_m [3][19];
  int   shd_m [3][19];
  int   stall_bad, pend_cycles, pend_ready_bad;
  src_t src_q [$];
  pix_t exp_q [$];
  pix_t got_q [$];

  color_xform_poly #(.DW(8), .XYW(10), .CW(18), .FRAC(10)) dut (
    .clk_25(clk_25), .reset(reset), .valid(valid), .ready(ready),
    .x_i(x_i), .y_i(y_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .bypass(bypass), .wrfull(wrfull), .wrreq(wrreq), .wrclk_25(wrclk_25),
    .x_o(x_o), .y_o(y_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending)
  );

  initial begin
    clk_25 = 1'b0;
    forever #5 clk_25 = ~clk_25;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk_25)
    if (reset === 1'b1 && wrreq === 1'b1) got_q.push_back({x_o, y_o, red_o, green_o, blue_o});

  function automatic pix_t model(src_t s);
    pix_t   o;
    longint rr, gg, bb, acc, q;
    longint m [19];
    int     v [3];
    rr = s.r; gg = s.g; bb = s.b;
    m = '{rr*rr*rr, gg*gg*gg, bb*bb*bb, rr*rr*gg, rr*gg*gg, gg*gg*bb, gg*bb*bb, bb*bb*rr,
          bb*rr*rr, rr*rr, gg*gg, bb*bb, rr*gg, gg*bb, bb*rr, rr, gg, bb, 1};
    for (int c = 0; c < 3; c++) begin
      acc = 0;
      for (int t = 0; t < 19; t++) acc += longint'(act_m[c][t]) * m[t];
      q = (acc + 512) >>> 10;
      v[c] = (q < 0) ? 0 : (q > 255) ? 255 : int'(q);
    end
    o.x = s.x; o.y = s.y;
    if (s.byp) begin o.r = s.r; o.g = s.g; o.b = s.b; end
    else begin o.r = 8'(v[0]); o.g = 8'(v[1]); o.b = 8'(v[2]); end
    return o;
  endfunction

  function automatic src_t rnd_pix(bit byp);
    return {byp, 10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  task automatic set_ident();
    for (int c = 0; c < 3; c++)
      for (int t = 0; t < 19; t++) begin
        act_m[c][t] = (t == 15 + c) ? 1024 : 0;
        shd_m[c][t] = act_m[c][t];
      end
  endtask

  task automatic cfg_write(input int ch, input int idx, input int val);
    @(posedge clk_25); #1;
    cfg_we = 1'b1; cfg_addr = {2'(ch), 5'(idx)}; cfg_data = 18'(val);
    if (ch < 3 && idx < 19) shd_m[ch][idx] = val;
    @(posedge clk_25); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_commit();
    int n = 0;
    @(posedge clk_25); #1;
    cfg_commit = 1'b1;
    act_m = shd_m;
    @(posedge clk_25); #1;
    cfg_commit = 1'b0;
    tests++;
    if (commit_pending !== 1'b1) begin fails++; $display("FAIL commit_set: got %b exp 1", commit_pending); end
    while (commit_pending === 1'b1 && n < 50) begin @(posedge clk_25); #1; n++; end
    tests++;
    if (commit_pending !== 1'b0) begin fails++; $display("FAIL commit_clear: got %b exp 0", commit_pending); end
  endtask

  // Drives src_q one pixel per cycle, holding a pixel until it is accepted.
  task automatic stream(input int stall_at, input int stall_len, input int commit_at);
    int k = 0;
    stall_bad = 0; pend_cycles = 0; pend_ready_bad = 0;
    while (k < 400 && (src_q.size() > 0 || k <= commit_at || k < stall_at + stall_len)) begin
      @(posedge clk_25); #1;
      wrfull     = (k >= stall_at) && (k < stall_at + stall_len);
      cfg_commit = (k == commit_at);
      valid      = (src_q.size() > 0);
      if (valid) {bypass, x_i, y_i, red_i, green_i, blue_i} = src_q[0];
      #1;
      if (ready !== !wrfull) stall_bad++;
      if (commit_pending === 1'b1) begin
        pend_cycles++;
        if (ready !== 1'b0) pend_ready_bad++;
      end
      if (valid && ready) begin
        exp_q.push_back(model(src_q[0]));
        void'(src_q.pop_front());
      end
      if (cfg_commit) act_m = shd_m;
      k++;
    end
    @(posedge clk_25); #1;
    valid = 1'b0; cfg_commit = 1'b0; wrfull = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_25);
      if (got_q.size() >= exp_q.size() && commit_pending === 1'b0 && wrreq === 1'b0) break;
    end
    repeat (3) @(negedge clk_25);
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b0; bypass = 1'b0; wrfull = 1'b0;
    cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
    x_i = '0; y_i = '0; red_i = '0; green_i = '0; blue_i = '0;
    set_ident();
    #12;
    tests++;
    if (wrreq !== 1'b0) begin fails++; $display("FAIL reset_wrreq: got %b exp 0", wrreq); end
    tests++;
    if ({x_o, y_o, red_o, green_o, blue_o} !== 44'd0) begin
      fails++; $display("FAIL reset_outputs: got %h exp 0", {x_o, y_o, red_o, green_o, blue_o});
    end
    tests++;
    if (commit_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b exp 0", commit_pending); end
    @(posedge clk_25); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_25);
    #1;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", ready); end
    tests++;
    if (wrclk_25 !== clk_25) begin fails++; $display("FAIL wrclk: got %b exp %b", wrclk_25, clk_25); end
  endtask

  task automatic test_latency();
    pix_t want = {10'd5, 10'd7, 8'd10, 8'd20, 8'd30};
    @(posedge clk_25); #1;
    valid = 1'b1; bypass = 1'b0; x_i = 10'd5; y_i = 10'd7;
    red_i = 8'd10; green_i = 8'd20; blue_i = 8'd30;
    #1;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL latency_ready: got %b exp 1", ready); end
    @(posedge clk_25); #1;
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25);
      tests++;
      if (wrreq !== 1'b0) begin fails++; $display("FAIL latency_early cycle %0d: got %b exp 0", i, wrreq); end
    end
    @(negedge clk_25);
    tests++;
    if (wrreq !== 1'b1) begin fails++; $display("FAIL latency_wrreq: got %b exp 1", wrreq); end
    tests++;
    if ({x_o, y_o, red_o, green_o, blue_o} !== want) begin
      fails++; $display("FAIL latency_data: got %h exp %h", {x_o, y_o, red_o, green_o, blue_o}, want);
    end
    repeat (3) @(negedge clk_25);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_identity_random();
    for (int i = 0; i < 10; i++) src_q.push_back(rnd_pix(1'b0));
    stream(1000, 0, -1);
    drain();
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL ident_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ident_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_swap();
    cfg_write(0, 16, 1024); cfg_write(0, 15, 0);
    cfg_write(1, 15, 1024); cfg_write(1, 16, 0);
    do_commit();
    src_q.push_back({1'b0, 10'd5, 10'd7, 8'd10, 8'd20, 8'd30});
    for (int i = 0; i < 6; i++) src_q.push_back(rnd_pix(1'b0));
    stream(1000, 0, -1);
    drain();
    tests++;
    if (got_q.size() < 1 || got_q[0] !== {10'd5, 10'd7, 8'd20, 8'd10, 8'd30}) begin
      fails++; $display("FAIL swap_direct: got %h exp %h", got_q.size() ? got_q[0] : 44'd0, {10'd5, 10'd7, 8'd20, 8'd10, 8'd30});
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL swap_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL swap_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_clamp();
    int want [3] = '{255, 0, 10};
    for (int s = 0; s < 3; s++) begin
      if (s == 0) begin cfg_write(0, 15, 2048); src_q.push_back({1'b0, 10'd1, 10'd2, 8'd200, 8'd50, 8'd60}); end
      if (s == 1) begin cfg_write(0, 18, -131072); src_q.push_back({1'b0, 10'd1, 10'd2, 8'd20, 8'd0, 8'd60}); end
      if (s == 2) begin
        cfg_write(0, 15, 0); cfg_write(0, 16, 0); cfg_write(0, 18, 0); cfg_write(0, 9, 1);
        src_q.push_back({1'b0, 10'd1, 10'd2, 8'd100, 8'd0, 8'd60});
      end
      do_commit();
      stream(1000, 0, -1);
      drain();
      tests++;
      if (got_q.size() != 1 || int'(got_q[0].r) != want[s]) begin
        fails++; $display("FAIL clamp_%0d: got %0d exp %0d", s, got_q.size() ? int'(got_q[0].r) : -1, want[s]);
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) src_q.push_back(rnd_pix(1'b0));
    stream(5, 3, -1);
    drain();
    tests++;
    if (stall_bad != 0) begin fails++; $display("FAIL stall_ready: got %0d bad cycles exp 0", stall_bad); end
    tests++;
    if (got_q.size() != 8) begin fails++; $display("FAIL stall_count: got %0d exp 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_commit_burst();
    cfg_write(0, 9, 0); cfg_write(0, 15, 1024);
    for (int i = 0; i < 5; i++) src_q.push_back(rnd_pix(1'b0));
    stream(1000, 0, 2);
    drain();
    tests++;
    if (pend_cycles < 3) begin fails++; $display("FAIL commit_pend_len: got %0d exp >=3", pend_cycles); end
    tests++;
    if (pend_ready_bad != 0) begin fails++; $display("FAIL commit_ready: got %0d bad cycles exp 0", pend_ready_bad); end
    tests++;
    if (got_q.size() != 5) begin fails++; $display("FAIL commit_count: got %0d exp 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL commit_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_bank();
    int v;
    for (int c = 0; c < 3; c++)
      for (int t = 0; t < 19; t++) begin
        if (t < 9)        v = int'($urandom_range(0, 2)) - 1;
        else if (t < 15)  v = int'($urandom_range(0, 16)) - 8;
        else if (t < 18)  v = (t == 15 + c) ? int'($urandom_range(256, 1024)) : int'($urandom_range(0, 512)) - 256;
        else              v = int'($urandom_range(0, 131072)) - 65536;
        cfg_write(c, t, v);
      end
    cfg_write(3, 15, 999);
    cfg_write(0, 25, 999);
    do_commit();
    for (int i = 0; i < 12; i++) src_q.push_back(rnd_pix(1'b0));
    stream(1000, 0, -1);
    drain();
    tests++;
    if (got_q.size() != 12) begin fails++; $display("FAIL rbank_count: got %0d exp 12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rbank_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 10; i++) src_q.push_back(rnd_pix(i % 3 != 2));
    stream(1000, 0, -1);
    drain();
    tests++;
    if (got_q.size() != 10) begin fails++; $display("FAIL bypass_count: got %0d exp 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bypass_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_25); #1;
      valid = 1'b1;
      {bypass, x_i, y_i, red_i, green_i, blue_i} = rnd_pix(1'b0);
      cfg_commit = (k == 3);
    end
    @(posedge clk_25); #1;
    valid = 1'b0; cfg_commit = 1'b0;
    tests++;
    if (commit_pending !== 1'b1) begin fails++; $display("FAIL rmid_pending_before: got %b exp 1", commit_pending); end
    reset = 1'b0;
    #1;
    tests++;
    if (wrreq !== 1'b0) begin fails++; $display("FAIL rmid_wrreq: got %b exp 0", wrreq); end
    tests++;
    if ({x_o, y_o, red_o, green_o, blue_o} !== 44'd0) begin
      fails++; $display("FAIL rmid_outputs: got %h exp 0", {x_o, y_o, red_o, green_o, blue_o});
    end
    tests++;
    if (commit_pending !== 1'b0) begin fails++; $display("FAIL rmid_pending: got %b exp 0", commit_pending); end
    repeat (2) @(posedge clk_25);
    #1;
    reset = 1'b1;
    got_q.delete(); exp_q.delete();
    set_ident();
    do_commit();
    src_q.push_back({1'b0, 10'd5, 10'd7, 8'd10, 8'd20, 8'd30});
    for (int i = 0; i < 4; i++) src_q.push_back(rnd_pix(1'b0));
    stream(1000, 0, -1);
    drain();
    tests++;
    if (got_q.size() < 1 || got_q[0] !== {10'd5, 10'd7, 8'd10, 8'd20, 8'd30}) begin
      fails++; $display("FAIL rmid_identity: got %h exp %h", got_q.size() ? got_q[0] : 44'd0, {10'd5, 10'd7, 8'd10, 8'd20, 8'd30});
    end
    tests++;
    if (got_q.size() != 5) begin fails++; $display("FAIL rmid_count: got %0d exp 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_pix %0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_identity_random();
    test_swap();
    test_clamp();
    test_stall();
    test_commit_burst();
    test_random_bank();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
